// File: rtl/bp2wb_pkg.sv
// Shared types and message-width derivation for the BP-to-Wishbone bridge and its
// command arbiter.
package bp2wb_pkg;

    typedef enum logic {e_bp_single_core_cfg} bp_params_e;

    typedef struct packed {
        int unsigned paddr_width;
        int unsigned cce_block_width;
        int unsigned lce_id_width;
        int unsigned lce_assoc;
    } bp_proc_param_s;

    localparam int unsigned bp_mem_msg_type_width_lp = 4;
    localparam int unsigned bp_mem_msg_size_width_lp = 3;
    localparam int unsigned bp_coh_state_width_lp    = 3;

    typedef enum logic {IDLE, WAIT} bp_arb_state_e;
    typedef logic bp_port_idx_t;

    function automatic bp_proc_param_s bp_get_proc_params(input bp_params_e cfg);
        bp_proc_param_s p;
        p.paddr_width     = 40;
        p.cce_block_width = 512;
        p.lce_id_width    = 4;
        p.lce_assoc       = 8;
        if (cfg != e_bp_single_core_cfg) p.lce_id_width = 8;
        return p;
    endfunction

    // Header (type, size, address, lce/way/state payload) followed by the data block.
    function automatic int unsigned cce_mem_msg_width(input bp_params_e cfg);
        bp_proc_param_s p;
        p = bp_get_proc_params(cfg);
        return bp_mem_msg_type_width_lp + bp_mem_msg_size_width_lp + p.paddr_width
             + p.lce_id_width + $clog2(p.lce_assoc) + bp_coh_state_width_lp
             + p.cce_block_width;
    endfunction

endpackage

// File: rtl/bp_mem_one_entry_buffer.sv
// Single-entry command holding register; ready only while empty, so a drain cycle
// can never be a refill cycle.
module bp_mem_one_entry_buffer #(
    parameter int unsigned width_p = 1
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic [width_p-1:0] data_i,
    input  logic               v_i,
    output logic               ready_o,
    output logic [width_p-1:0] data_o,
    output logic               v_o,
    input  logic               clear_i
);

    logic               full_q;
    logic [width_p-1:0] data_q;

    assign ready_o = !full_q;
    assign v_o     = full_q;
    assign data_o  = data_q;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else if (clear_i) begin
            full_q <= 1'b0;
        end else if (v_i && ready_o) begin
            full_q <= 1'b1;
            data_q <= data_i;
        end
    end

endmodule

// File: rtl/bp_mem_cmd_arbiter.sv
// Round-robin merge of the cached and uncached BP command channels into one converter
// port, with one transaction in flight and responses steered back to the issuer.
module bp_mem_cmd_arbiter
    import bp2wb_pkg::*;
#(
    parameter bp_params_e bp_params_p = e_bp_single_core_cfg,
    localparam int unsigned msg_width_lp = cce_mem_msg_width(bp_params_p)
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,

    input  logic [msg_width_lp-1:0] p0_mem_cmd_i,
    input  logic                    p0_mem_cmd_v_i,
    output logic                    p0_mem_cmd_ready_o,
    output logic [msg_width_lp-1:0] p0_mem_resp_o,
    output logic                    p0_mem_resp_v_o,
    input  logic                    p0_mem_resp_yumi_i,

    input  logic [msg_width_lp-1:0] p1_mem_cmd_i,
    input  logic                    p1_mem_cmd_v_i,
    output logic                    p1_mem_cmd_ready_o,
    output logic [msg_width_lp-1:0] p1_mem_resp_o,
    output logic                    p1_mem_resp_v_o,
    input  logic                    p1_mem_resp_yumi_i,

    output logic [msg_width_lp-1:0] mem_cmd_o,
    output logic                    mem_cmd_v_o,
    input  logic                    mem_cmd_ready_i,
    input  logic [msg_width_lp-1:0] mem_resp_i,
    input  logic                    mem_resp_v_i,
    output logic                    mem_resp_yumi_o,
    output logic                    protocol_err_o
);

    logic [msg_width_lp-1:0] p0_data, p1_data;
    logic [1:0]              buf_full, buf_clear;

    bp_mem_one_entry_buffer #(.width_p(msg_width_lp)) u_buf0 (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .data_i    (p0_mem_cmd_i),
        .v_i       (p0_mem_cmd_v_i),
        .ready_o   (p0_mem_cmd_ready_o),
        .data_o    (p0_data),
        .v_o       (buf_full[0]),
        .clear_i   (buf_clear[0])
    );

    bp_mem_one_entry_buffer #(.width_p(msg_width_lp)) u_buf1 (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .data_i    (p1_mem_cmd_i),
        .v_i       (p1_mem_cmd_v_i),
        .ready_o   (p1_mem_cmd_ready_o),
        .data_o    (p1_data),
        .v_o       (buf_full[1]),
        .clear_i   (buf_clear[1])
    );

    bp_arb_state_e state_q, state_d;
    bp_port_idx_t  grant_q, grant_d, last_grant_q, last_grant_d, sel;
    logic          err_q, err_d;

    assign p0_mem_resp_o  = mem_resp_i;
    assign p1_mem_resp_o  = mem_resp_i;
    assign protocol_err_o = err_q;

    // Ties go to the port not served last; otherwise the only full buffer wins.
    assign sel = (buf_full[0] && buf_full[1]) ? !last_grant_q : buf_full[1];

    always_comb begin
        state_d         = state_q;
        grant_d         = grant_q;
        last_grant_d    = last_grant_q;
        buf_clear       = '0;
        mem_cmd_o       = sel ? p1_data : p0_data;
        mem_cmd_v_o     = 1'b0;
        mem_resp_yumi_o = 1'b0;
        p0_mem_resp_v_o = 1'b0;
        p1_mem_resp_v_o = 1'b0;
        case (state_q)
            IDLE: begin
                if ((|buf_full) && mem_cmd_ready_i) begin
                    mem_cmd_v_o    = 1'b1;
                    buf_clear[sel] = 1'b1;
                    grant_d        = sel;
                    state_d        = WAIT;
                end
            end
            WAIT: begin
                p0_mem_resp_v_o = !grant_q && mem_resp_v_i;
                p1_mem_resp_v_o =  grant_q && mem_resp_v_i;
                mem_resp_yumi_o = mem_resp_v_i
                                && (grant_q ? p1_mem_resp_yumi_i : p0_mem_resp_yumi_i);
                if (mem_resp_yumi_o) begin
                    last_grant_d = grant_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        err_d = err_q
              || (state_q == IDLE && mem_resp_v_i)
              || (p0_mem_resp_yumi_i && !p0_mem_resp_v_o)
              || (p1_mem_resp_yumi_i && !p1_mem_resp_v_o);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            err_q        <= err_d;
        end
    end

endmodule

// File: tb/tb_bp_mem_cmd_arbiter.sv
// Scoreboard bench for bp_mem_cmd_arbiter: expected commands queued at drive time,
// popped when the arbiter strobes mem_cmd_v_o; inputs driven and outputs sampled on negedge.
module tb_bp_mem_cmd_arbiter;
    import bp2wb_pkg::*;

    localparam int unsigned W = cce_mem_msg_width(e_bp_single_core_cfg);

    logic         clk_i = 1'b0;
    logic         reset_n_i;
    logic [W-1:0] p0_mem_cmd_i, p1_mem_cmd_i, p0_mem_resp_o, p1_mem_resp_o;
    logic         p0_mem_cmd_v_i, p0_mem_cmd_ready_o, p0_mem_resp_v_o, p0_mem_resp_yumi_i;
    logic         p1_mem_cmd_v_i, p1_mem_cmd_ready_o, p1_mem_resp_v_o, p1_mem_resp_yumi_i;
    logic [W-1:0] mem_cmd_o, mem_resp_i;
    logic         mem_cmd_v_o, mem_cmd_ready_i, mem_resp_v_i, mem_resp_yumi_o, protocol_err_o;

    always #5 clk_i = ~clk_i;

    bp_mem_cmd_arbiter #(.bp_params_p(e_bp_single_core_cfg)) dut (
        .clk_i              (clk_i),
        .reset_n_i          (reset_n_i),
        .p0_mem_cmd_i       (p0_mem_cmd_i),
        .p0_mem_cmd_v_i     (p0_mem_cmd_v_i),
        .p0_mem_cmd_ready_o (p0_mem_cmd_ready_o),
        .p0_mem_resp_o      (p0_mem_resp_o),
        .p0_mem_resp_v_o    (p0_mem_resp_v_o),
        .p0_mem_resp_yumi_i (p0_mem_resp_yumi_i),
        .p1_mem_cmd_i       (p1_mem_cmd_i),
        .p1_mem_cmd_v_i     (p1_mem_cmd_v_i),
        .p1_mem_cmd_ready_o (p1_mem_cmd_ready_o),
        .p1_mem_resp_o      (p1_mem_resp_o),
        .p1_mem_resp_v_o    (p1_mem_resp_v_o),
        .p1_mem_resp_yumi_i (p1_mem_resp_yumi_i),
        .mem_cmd_o          (mem_cmd_o),
        .mem_cmd_v_o        (mem_cmd_v_o),
        .mem_cmd_ready_i    (mem_cmd_ready_i),
        .mem_resp_i         (mem_resp_i),
        .mem_resp_v_i       (mem_resp_v_i),
        .mem_resp_yumi_o    (mem_resp_yumi_o),
        .protocol_err_o     (protocol_err_o)
    );

    typedef struct {
        logic         port;
        logic [W-1:0] data;
    } sb_item_t;

    sb_item_t    sb_q[$];
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [W-1:0] mk(input logic [39:0] addr, input logic [31:0] tag);
        logic [W-1:0] r;
        r             = '0;
        r[39:0]       = addr;
        r[300 +: 32]  = $urandom;
        r[W-1 -: 32]  = tag;
        return r;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_v"},    W'(mem_cmd_v_o),        W'(0));
        check({tag, "_yumi"},     W'(mem_resp_yumi_o),    W'(0));
        check({tag, "_p0_rv"},    W'(p0_mem_resp_v_o),    W'(0));
        check({tag, "_p1_rv"},    W'(p1_mem_resp_v_o),    W'(0));
        check({tag, "_p0_ready"}, W'(p0_mem_cmd_ready_o), W'(1));
        check({tag, "_p1_ready"}, W'(p1_mem_cmd_ready_o), W'(1));
        check({tag, "_err"},      W'(protocol_err_o),     W'(0));
    endtask

    // Called at a negedge; drives one accept cycle and queues expected issue order.
    task automatic drive_cmd(input logic v0, input logic [W-1:0] d0,
                             input logic v1, input logic [W-1:0] d1, input logic first);
        sb_item_t a, b;
        p0_mem_cmd_v_i = v0; p0_mem_cmd_i = d0;
        p1_mem_cmd_v_i = v1; p1_mem_cmd_i = d1;
        a.port = 1'b0; a.data = d0;
        b.port = 1'b1; b.data = d1;
        #1;
        if (v0) check("p0_accept_ready", W'(p0_mem_cmd_ready_o), W'(1));
        if (v1) check("p1_accept_ready", W'(p1_mem_cmd_ready_o), W'(1));
        if (v0 && v1) begin
            if (first) begin sb_q.push_back(b); sb_q.push_back(a); end
            else       begin sb_q.push_back(a); sb_q.push_back(b); end
        end else if (v0) sb_q.push_back(a);
        else if (v1)     sb_q.push_back(b);
        @(negedge clk_i);
        p0_mem_cmd_v_i = 1'b0;
        p1_mem_cmd_v_i = 1'b0;
    endtask

    // Called at a negedge; waits (bounded) for an issue, checks it, then runs the response.
    task automatic serve(input int unsigned yumi_delay, input int unsigned exp_latency);
        sb_item_t     e;
        int unsigned  n;
        logic [W-1:0] resp;
        n = 0;
        #1;
        while (mem_cmd_v_o !== 1'b1 && n < 20) begin
            @(negedge clk_i); #1; n++;
        end
        check("issue_latency", W'(n), W'(exp_latency));
        check("sb_pending", W'(sb_q.size() != 0), W'(1));
        if (n >= 20 || sb_q.size() == 0) return;
        e = sb_q.pop_front();
        check("cmd_data", mem_cmd_o, e.data);
        check("drain_ready", W'(e.port ? p1_mem_cmd_ready_o : p0_mem_cmd_ready_o), W'(0));
        resp = ~e.data;
        @(negedge clk_i);
        p0_mem_cmd_v_i = 1'b0;
        p1_mem_cmd_v_i = 1'b0;
        mem_resp_i     = resp;
        mem_resp_v_i   = 1'b1;
        for (int unsigned i = 0; i <= yumi_delay; i++) begin
            if (i == yumi_delay) begin
                if (e.port) p1_mem_resp_yumi_i = 1'b1;
                else        p0_mem_resp_yumi_i = 1'b1;
            end
            #1;
            check("resp_v_granted", W'(e.port ? p1_mem_resp_v_o : p0_mem_resp_v_o), W'(1));
            check("resp_v_other",   W'(e.port ? p0_mem_resp_v_o : p1_mem_resp_v_o), W'(0));
            check("resp_data_p0",   p0_mem_resp_o, resp);
            check("resp_data_p1",   p1_mem_resp_o, resp);
            check("cmd_v_in_wait",  W'(mem_cmd_v_o), W'(0));
            check("yumi_o",         W'(mem_resp_yumi_o), W'(i == yumi_delay));
            @(negedge clk_i);
        end
        mem_resp_v_i       = 1'b0;
        p0_mem_resp_yumi_i = 1'b0;
        p1_mem_resp_yumi_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        sb_item_t e;
        reset_n_i = 1'b0;
        p0_mem_cmd_i = '0; p0_mem_cmd_v_i = 1'b0; p0_mem_resp_yumi_i = 1'b0;
        p1_mem_cmd_i = '0; p1_mem_cmd_v_i = 1'b0; p1_mem_resp_yumi_i = 1'b0;
        mem_cmd_ready_i = 1'b1; mem_resp_i = '0; mem_resp_v_i = 1'b0;
        #2;
        check_reset_outputs("rst");
        @(negedge clk_i);
        reset_n_i = 1'b1;

        // single port-0 command
        drive_cmd(1'b1, mk(40'h00_8000_0040, 32'h11), 1'b0, '0, 1'b0);
        serve(0, 0);
        #1 check("idle_after_single", W'(mem_cmd_v_o), W'(0));
        @(negedge clk_i);

        // reset between transactions restores port-0 priority on ties
        reset_n_i = 1'b0;
        #1 check_reset_outputs("rst2");
        @(negedge clk_i);
        reset_n_i = 1'b1;

        drive_cmd(1'b1, mk(40'h00_8000_0100, 32'h21), 1'b1, mk(40'h00_0010_0000, 32'h22), 1'b0);
        serve(0, 0);
        serve(0, 0);
        drive_cmd(1'b1, mk(40'h00_8000_0140, 32'h23), 1'b0, '0, 1'b0);
        serve(0, 0);
        drive_cmd(1'b1, mk(40'h00_8000_0180, 32'h24), 1'b1, mk(40'h00_0010_0008, 32'h25), 1'b1);
        serve(0, 0);
        serve(0, 0);
        drive_cmd(1'b1, mk(40'h00_8000_01c0, 32'h26), 1'b1, mk(40'h00_0010_0010, 32'h27), 1'b1);
        serve(0, 0);
        serve(0, 0);

        // converter not ready with both full, then delayed yumi on port 1
        mem_cmd_ready_i = 1'b0;
        drive_cmd(1'b1, mk(40'h00_8000_0200, 32'h31), 1'b1, mk(40'h00_0010_0018, 32'h32), 1'b1);
        for (int unsigned i = 0; i < 5; i++) begin
            #1 check("no_issue_not_ready", W'(mem_cmd_v_o), W'(0));
            @(negedge clk_i);
        end
        mem_cmd_ready_i = 1'b1;
        serve(10, 0);
        serve(0, 0);

        // issue from port 0 while port 1 presents a new command
        drive_cmd(1'b1, mk(40'h00_8000_0240, 32'h41), 1'b0, '0, 1'b0);
        p1_mem_cmd_v_i = 1'b1;
        p1_mem_cmd_i   = mk(40'h00_0010_0020, 32'h42);
        e.port = 1'b1; e.data = p1_mem_cmd_i;
        sb_q.push_back(e);
        #1 check("p1_ready_during_issue", W'(p1_mem_cmd_ready_o), W'(1));
        serve(0, 0);
        serve(0, 0);

        // stray response in IDLE
        check("err_clean", W'(protocol_err_o), W'(0));
        @(negedge clk_i);
        mem_resp_v_i = 1'b1;
        mem_resp_i   = mk(40'h0, 32'hdead);
        #1;
        check("stray_yumi", W'(mem_resp_yumi_o), W'(0));
        check("stray_p0_rv", W'(p0_mem_resp_v_o), W'(0));
        @(negedge clk_i);
        mem_resp_v_i = 1'b0;
        #1 check("stray_err_set", W'(protocol_err_o), W'(1));
        repeat (3) @(negedge clk_i);
        #1 check("stray_err_sticky", W'(protocol_err_o), W'(1));
        @(negedge clk_i);

        // reset in WAIT with port 0 buffered behind the in-flight port-1 command
        drive_cmd(1'b0, '0, 1'b1, mk(40'h00_0010_0028, 32'h51), 1'b0);
        p0_mem_cmd_v_i = 1'b1;
        p0_mem_cmd_i   = mk(40'h00_8000_0280, 32'h52);
        #1;
        check("mid_issue", W'(mem_cmd_v_o), W'(1));
        if (sb_q.size() != 0) e = sb_q.pop_front();
        check("mid_cmd_data", mem_cmd_o, e.data);
        @(negedge clk_i);
        p0_mem_cmd_v_i = 1'b0;
        mem_resp_v_i   = 1'b1;
        mem_resp_i     = ~e.data;
        #1 check("mid_p1_rv", W'(p1_mem_resp_v_o), W'(1));
        check("mid_p0_full", W'(p0_mem_cmd_ready_o), W'(0));
        #2 reset_n_i = 1'b0;
        #1 check_reset_outputs("rst_mid");
        mem_resp_v_i = 1'b0;
        @(negedge clk_i);
        reset_n_i = 1'b1;
        drive_cmd(1'b1, mk(40'h00_8000_02c0, 32'h61), 1'b0, '0, 1'b0);
        serve(0, 0);
        #1 check("err_after_reset", W'(protocol_err_o), W'(0));
        check("sb_drained", W'(sb_q.size()), W'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
